// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch -- parametrised N-channel PWM generator
//
// Each channel runs its own counter against a double-buffered period/duty
// pair. New values are written into a shadow copy by LOAD and only move
// into the active copy at a period boundary (or immediately while the
// channel is disabled), so a running waveform never glitches.
//
// Parameters
//   CH_NUM  number of channels (1..32)
//   CNT_W   counter / period / duty width (2..32)
//
// Ports (channel i uses bit i, or slice [i*CNT_W +: CNT_W])
//   CLK         system clock
//   RST         synchronous active-high reset
//   CH_EN       per-channel enable (level)
//   LOAD        per-channel strobe: capture PERIOD/DUTY slice into shadow
//   PERIOD      per-channel period in cycles (0 behaves as 1)
//   DUTY        per-channel high time in cycles
//   CA_MODE     per-channel center-aligned select
//   PWM_OUT     registered PWM outputs
//   PERIOD_END  registered one-cycle pulse at each period boundary
//   PEND        shadow loaded but not yet active
//
// Build option
//   PWM_CENTER_ALIGN_EN  when defined, channels with CA_MODE=1 count
//                        0..P-1..1 (period 2*(P-1)); otherwise CA_MODE is
//                        ignored and no up/down logic exists.
// -----------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 28
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CH_NUM-1:0]       CH_EN,
    input  logic [CH_NUM-1:0]       LOAD,
    input  logic [CH_NUM*CNT_W-1:0] PERIOD,
    input  logic [CH_NUM*CNT_W-1:0] DUTY,
    input  logic [CH_NUM-1:0]       CA_MODE,
    output logic [CH_NUM-1:0]       PWM_OUT,
    output logic [CH_NUM-1:0]       PERIOD_END,
    output logic [CH_NUM-1:0]       PEND
);

`ifndef PWM_CENTER_ALIGN_EN
    // Center-aligned mode is not built; the select input has no function.
    logic ca_mode_unused;
    assign ca_mode_unused = ^CA_MODE;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] act_period_reg;
            logic [CNT_W-1:0] act_duty_reg;
            logic [CNT_W-1:0] sh_period_reg;
            logic [CNT_W-1:0] sh_duty_reg;
            logic             pend_reg;
            logic             pwm_reg;
            logic             period_end_reg;
            logic [CNT_W-1:0] last_cnt;
            logic             boundary;

            // Highest count value of the period: P-1 with P = max(period, 1).
            assign last_cnt = (act_period_reg == '0) ? '0
                                                     : act_period_reg - CNT_W'(1);

`ifdef PWM_CENTER_ALIGN_EN
            logic ca_reg;     // mode latched at boundary / while idle
            logic dir_reg;    // 0 = counting up, 1 = counting down
            logic ca_active;

            // A one-cycle period cannot turn around, so it runs edge-aligned.
            assign ca_active = ca_reg && (last_cnt != '0);
            // Center-aligned boundary is the step from 1 down to 0.
            assign boundary  = ca_active ? (dir_reg && (cnt_reg == CNT_W'(1)))
                                         : (cnt_reg == last_cnt);
`else
            assign boundary  = (cnt_reg == last_cnt);
`endif

            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_reg        <= '0;
                    act_period_reg <= '0;
                    act_duty_reg   <= '0;
                    sh_period_reg  <= '0;
                    sh_duty_reg    <= '0;
                    pend_reg       <= 1'b0;
                    pwm_reg        <= 1'b0;
                    period_end_reg <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                    ca_reg         <= 1'b0;
                    dir_reg        <= 1'b0;
`endif
                end else begin
                    if (!CH_EN[gi]) begin
                        // Idle: hold counter at 0 and apply pending values at once.
                        cnt_reg        <= '0;
                        pwm_reg        <= 1'b0;
                        period_end_reg <= 1'b0;
                        if (pend_reg) begin
                            act_period_reg <= sh_period_reg;
                            act_duty_reg   <= sh_duty_reg;
                        end
                        pend_reg       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                        dir_reg        <= 1'b0;
                        ca_reg         <= CA_MODE[gi];
`endif
                    end else begin
                        pwm_reg        <= (cnt_reg < act_duty_reg);
                        period_end_reg <= boundary;
                        if (boundary) begin
                            cnt_reg  <= '0;
                            if (pend_reg) begin
                                act_period_reg <= sh_period_reg;
                                act_duty_reg   <= sh_duty_reg;
                            end
                            pend_reg <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                            dir_reg  <= 1'b0;
                            ca_reg   <= CA_MODE[gi];
`endif
                        end else begin
`ifdef PWM_CENTER_ALIGN_EN
                            if (ca_active && dir_reg) begin
                                cnt_reg <= cnt_reg - CNT_W'(1);
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                                // Reaching the top flips direction so the top
                                // value is visited exactly once.
                                if (ca_active && ((cnt_reg + CNT_W'(1)) == last_cnt))
                                    dir_reg <= 1'b1;
                            end
`else
                            cnt_reg <= cnt_reg + CNT_W'(1);
`endif
                        end
                    end

                    // A load in the same cycle as a transfer lands in the shadow
                    // and stays pending for the next boundary.
                    if (LOAD[gi]) begin
                        sh_period_reg <= PERIOD[gi*CNT_W +: CNT_W];
                        sh_duty_reg   <= DUTY[gi*CNT_W +: CNT_W];
                        pend_reg      <= 1'b1;
                    end
                end
            end

            assign PWM_OUT[gi]    = pwm_reg;
            assign PERIOD_END[gi] = period_end_reg;
            assign PEND[gi]       = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch -- self-checking bench for pwm_multi_ch (4 channels, 8 bit)
// Expected PWM_OUT / PERIOD_END / PEND vectors are derived from the period,
// duty and cycle index of each scenario, queued when stimulus is applied and
// compared one cycle later when the registered outputs appear.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;
    localparam int CH = 4;
    localparam int W  = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [CH-1:0] CH_EN;
    logic [CH-1:0] LOAD;
    logic [CH*W-1:0] PERIOD;
    logic [CH*W-1:0] DUTY;
    logic [CH-1:0] CA_MODE;
    logic [CH-1:0] PWM_OUT;
    logic [CH-1:0] PERIOD_END;
    logic [CH-1:0] PEND;

    pwm_multi_ch #(.CH_NUM(CH), .CNT_W(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CH_EN      (CH_EN),
        .LOAD       (LOAD),
        .PERIOD     (PERIOD),
        .DUTY       (DUTY),
        .CA_MODE    (CA_MODE),
        .PWM_OUT    (PWM_OUT),
        .PERIOD_END (PERIOD_END),
        .PEND       (PEND)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [CH-1:0] pwm;
        logic [CH-1:0] pe;
        logic [CH-1:0] pend;
        string         name;
    } exp_t;

    typedef struct {
        int ch;
        int period;
        int duty;
        int cycles;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [CH-1:0] bitv(input int c, input bit b);
        logic [CH-1:0] one;
        one  = 4'b0001;
        bitv = b ? (one << c) : '0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the expectation for the edge about to happen, then compare.
    task automatic step(input logic [CH-1:0] pwm, input logic [CH-1:0] pe,
                        input logic [CH-1:0] pend, input string name);
        exp_t e;
        exp_t got;
        e.pwm  = pwm;
        e.pe   = pe;
        e.pend = pend;
        e.name = name;
        sb.push_back(e);
        tick();
        got = sb.pop_front();
        tests++;
        if (PWM_OUT !== got.pwm || PERIOD_END !== got.pe || PEND !== got.pend) begin
            fails++;
            $display("FAIL %s @%0t: pwm/pe/pend got %b/%b/%b, expected %b/%b/%b",
                     got.name, $time, PWM_OUT, PERIOD_END, PEND,
                     got.pwm, got.pe, got.pend);
        end
    endtask

    // Load a channel while every channel is disabled: PEND for one cycle,
    // then the idle transfer clears it.
    task automatic load_ch(input int c, input int p, input int d);
        LOAD           = '0;
        LOAD[c]        = 1'b1;
        PERIOD[c*W +: W] = 8'(p);
        DUTY[c*W +: W]   = 8'(d);
        step('0, '0, bitv(c, 1'b1), "load_pend");
        LOAD = '0;
        step('0, '0, '0, "load_xfer");
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{ch: 0, period: 10, duty: 3,  cycles: 30};
        vecs[1] = '{ch: 1, period: 8,  duty: 4,  cycles: 24};
        vecs[2] = '{ch: 0, period: 5,  duty: 0,  cycles: 12};
        vecs[3] = '{ch: 0, period: 5,  duty: 5,  cycles: 12};
        vecs[4] = '{ch: 0, period: 5,  duty: 20, cycles: 12};
        vecs[5] = '{ch: 3, period: 0,  duty: 1,  cycles: 6};
        vecs[6] = '{ch: 3, period: 0,  duty: 0,  cycles: 6};
        vecs[7] = '{ch: 2, period: 16, duty: 8,  cycles: 34};

        // Reset with every other input active: outputs stay low.
        RST     = 1'b1;
        CH_EN   = '1;
        LOAD    = '1;
        CA_MODE = '0;
        PERIOD  = '1;
        DUTY    = '1;
        step('0, '0, '0, "reset0");
        step('0, '0, '0, "reset1");
        RST   = 1'b0;
        LOAD  = '0;
        CH_EN = '0;
        for (int k = 0; k < 3; k++) step('0, '0, '0, "post_reset_idle");
        $display("[TB] reset/idle sequence done");

        // Table of steady-state waveforms.
        for (int i = 0; i < 8; i++) begin
            int c;
            int pe_eff;
            c      = vecs[i].ch;
            pe_eff = (vecs[i].period == 0) ? 1 : vecs[i].period;
            CH_EN  = '0;
            load_ch(c, vecs[i].period, vecs[i].duty);
            CH_EN[c] = 1'b1;
            for (int j = 0; j < vecs[i].cycles; j++) begin
                int m;
                m = j % pe_eff;
                step(bitv(c, m < vecs[i].duty), bitv(c, m == pe_eff - 1), '0, "table_run");
            end
            CH_EN = '0;
            step('0, '0, '0, "table_off");
            $display("[TB] vec %0d ch%0d period=%0d duty=%0d cycles=%0d", i, c,
                     vecs[i].period, vecs[i].duty, vecs[i].cycles);
        end

        // Glitch-free update on ch1: load mid-period, then at the boundary.
        CH_EN = '0;
        load_ch(1, 8, 4);
        CH_EN[1] = 1'b1;
        for (int j = 0; j < 32; j++) begin
            int  d;
            int  m;
            bit  pnd;
            LOAD = '0;
            if (j == 2)  begin LOAD[1] = 1'b1; DUTY[1*W +: W] = 8'd6; end
            if (j == 15) begin LOAD[1] = 1'b1; DUTY[1*W +: W] = 8'd2; end
            d   = (j < 8) ? 4 : ((j < 24) ? 6 : 2);
            m   = j % 8;
            pnd = (j >= 2 && j <= 6) || (j >= 15 && j <= 22);
            step(bitv(1, m < d), bitv(1, m == 7), bitv(1, pnd), "glitch_free");
        end
        LOAD  = '0;
        CH_EN = '0;
        step('0, '0, '0, "glitch_off");
        $display("[TB] glitch-free update sequence done");

        // Mid-period disable, clean restart, then reset mid-period on ch2.
        load_ch(2, 16, 8);
        CH_EN[2] = 1'b1;
        for (int j = 0; j < 5; j++) step(bitv(2, j < 8), '0, '0, "pre_disable");
        CH_EN = '0;
        for (int j = 0; j < 20; j++) step('0, '0, '0, "disabled_quiet");
        CH_EN[2] = 1'b1;
        for (int j = 0; j < 20; j++)
            step(bitv(2, (j % 16) < 8), bitv(2, (j % 16) == 15), '0, "reenable");
        RST     = 1'b1;
        LOAD[2] = 1'b1;
        step('0, '0, '0, "mid_reset");
        RST  = 1'b0;
        LOAD = '0;
        // Active values were cleared: period 0 acts as 1, duty 0 keeps output low.
        for (int j = 0; j < 4; j++) step('0, bitv(2, 1'b1), '0, "after_reset");
        CH_EN = '0;
        step('0, '0, '0, "after_reset_off");
        $display("[TB] disable/reset sequence done");

`ifdef PWM_CENTER_ALIGN_EN
        // ch3 center-aligned P=6 D=2 alongside ch0 edge-aligned P=7 D=3.
        CA_MODE[3] = 1'b1;
        load_ch(3, 6, 2);
        load_ch(0, 7, 3);
        CH_EN = 4'b1001;
        for (int j = 0; j < 30; j++) begin
            int jm;
            int cc;
            jm = j % 10;
            cc = (jm <= 5) ? jm : 10 - jm;
            step(bitv(3, cc < 2) | bitv(0, (j % 7) < 3),
                 bitv(3, jm == 9) | bitv(0, (j % 7) == 6), '0, "center_align");
        end
        CH_EN   = '0;
        CA_MODE = '0;
        step('0, '0, '0, "center_off");
        $display("[TB] center-aligned sequence done");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
